// File: rtl/stream_demux_n_pkg.sv
// Shared definitions for the stream_demux_n slice: FSM encoding and the
// select-width helper used by the interface and the top level.
package stream_demux_n_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUTE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  // Bits needed to encode n channels, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_demux_n_if.sv
// Input stream plus per-channel output bundle of the 1:N demultiplexer.
// master = packet source / channel sinks, slave = the demux itself.
interface stream_demux_n_if #(
  parameter int N_CH = 4,
  parameter int DW   = 8
);
  import stream_demux_n_pkg::*;

  localparam int SEL_W = clog2_min1(N_CH);

  logic [DW-1:0]      in_data;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic               in_last;
  logic [N_CH*DW-1:0] out_data;
  logic [N_CH-1:0]    out_valid;
  logic [N_CH-1:0]    out_last;
  logic [N_CH-1:0]    out_ready;
  logic               busy;
  logic               err_sel;

  modport master (
    output in_data, in_valid, in_sel, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, err_sel
  );

  modport slave (
    input  in_data, in_valid, in_sel, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, err_sel
  );

endinterface

// File: rtl/stream_demux_n_out_reg.sv
// One-entry output register for a single channel; a load in the same cycle
// as a drain keeps the register full so a channel sustains one beat per cycle.
module stream_demux_n_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  input  logic          d_last,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] q,
  output logic          q_last
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data/last payload is reset too, so the bus reads a clean
      // zero after reset instead of stale data from an abandoned packet.
      valid  <= 1'b0;
      q      <= '0;
      q_last <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      q      <= d;
      q_last <= d_last;
    end else if (valid && ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1:N packet demultiplexer: the head beat picks the channel, the
// rest of the packet follows it; invalid selects are swallowed and flagged.
module stream_demux_n
  import stream_demux_n_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_n_if.slave  bus
);

  localparam int SEL_W = clog2_min1(N_CH);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [SEL_W-1:0] cur_ch;
  logic [SEL_W-1:0] eff_ch;
  logic             sel_ok;
  logic             route;
  logic             ch_free;
  logic             accept;
  logic             head;
  logic [N_CH-1:0]  load;

  assign eff_ch = (state == ST_IDLE) ? bus.in_sel : cur_ch;
  assign sel_ok = int'(bus.in_sel) < N_CH;
  assign route  = (state == ST_ROUTE) || ((state == ST_IDLE) && sel_ok);
  assign head   = accept && (state == ST_IDLE);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    ch_free = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (eff_ch == SEL_W'(c)) ch_free = ~bus.out_valid[c] | bus.out_ready[c];
    end
  end

  // Dropped beats are always accepted; routed beats wait for their channel.
  assign bus.in_ready = rst_n & (~route | ch_free);
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.busy     = rst_n & (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (accept && !bus.in_last) state_nx = sel_ok ? ST_ROUTE : ST_DROP;
      ST_ROUTE, ST_DROP:
        if (accept && bus.in_last) state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_ch      <= '0;
      bus.err_sel <= 1'b0;
    end else begin
      state       <= state_nx;
      if (head && sel_ok) cur_ch <= bus.in_sel;
      bus.err_sel <= head && !sel_ok;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign load[c] = accept && route && (eff_ch == SEL_W'(c));

    stream_demux_n_out_reg #(.DW(DW)) u_out_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[c]),
      .d      (bus.in_data),
      .d_last (bus.in_last),
      .ready  (bus.out_ready[c]),
      .valid  (bus.out_valid[c]),
      .q      (bus.out_data[c*DW +: DW]),
      .q_last (bus.out_last[c])
    );
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Scoreboarded bench for stream_demux_n: a 4-channel and a 3-channel instance,
// directed packets push expected beats per channel, negedge monitors pop them.
module tb_stream_demux_n;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_demux_n_if #(.N_CH(4), .DW(8)) if4 ();
  stream_demux_n_if #(.N_CH(3), .DW(8)) if3 ();

  stream_demux_n #(.N_CH(4), .DW(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  stream_demux_n #(.N_CH(3), .DW(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  beat_t q4[4][$];
  beat_t q3[3][$];
  int checks = 0;
  int errors = 0;
  int busy4_cyc = 0;
  int err4_cyc = 0;
  int err3_cyc = 0;
  int st[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every completed output handshake must match the head of its queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (if4.busy)    busy4_cyc++;
      if (if4.err_sel) err4_cyc++;
      if (if3.err_sel) err3_cyc++;
      for (int c = 0; c < 4; c++) begin
        if (if4.out_valid[c] && if4.out_ready[c]) begin
          check($sformatf("d4_ch%0d_beat_expected", c), 32'(q4[c].size() > 0), 1);
          if (q4[c].size() > 0) begin
            e = q4[c].pop_front();
            check($sformatf("d4_ch%0d_data", c), 32'(if4.out_data[c*8 +: 8]), 32'(e.data));
            check($sformatf("d4_ch%0d_last", c), 32'(if4.out_last[c]), 32'(e.last));
          end
        end
      end
      for (int c = 0; c < 3; c++) begin
        if (if3.out_valid[c] && if3.out_ready[c]) begin
          check($sformatf("d3_ch%0d_beat_expected", c), 32'(q3[c].size() > 0), 1);
          if (q3[c].size() > 0) begin
            e = q3[c].pop_front();
            check($sformatf("d3_ch%0d_data", c), 32'(if3.out_data[c*8 +: 8]), 32'(e.data));
            check($sformatf("d3_ch%0d_last", c), 32'(if3.out_last[c]), 32'(e.last));
          end
        end
      end
    end
  end

  // Present one beat, wait (bounded) for acceptance, push the expected beat
  // onto exp_ch's queue (exp_ch < 0: beat must be discarded).
  task automatic send(input bit d3, input int sel, input logic [7:0] data, input bit last,
                      input int exp_ch, output int stalls);
    beat_t b;
    stalls = 0;
    b.data = data;
    b.last = last;
    if (d3) begin
      if3.in_valid = 1'b1; if3.in_sel = 2'(sel); if3.in_data = data; if3.in_last = last;
    end else begin
      if4.in_valid = 1'b1; if4.in_sel = 2'(sel); if4.in_data = data; if4.in_last = last;
    end
    @(negedge clk);
    while (!(d3 ? if3.in_ready : if4.in_ready) && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 40) begin
      check("send_timeout", 32'(stalls), 0);
    end else if (exp_ch >= 0) begin
      if (d3) q3[exp_ch].push_back(b);
      else    q4[exp_ch].push_back(b);
    end
    @(posedge clk);
    #1;
    if3.in_valid = 1'b0;
    if4.in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    int base;
    if4.in_valid = 1'b0; if4.in_sel = '0; if4.in_data = '0; if4.in_last = 1'b0;
    if3.in_valid = 1'b0; if3.in_sel = '0; if3.in_data = '0; if3.in_last = 1'b0;
    if4.out_ready = 4'hF;
    if3.out_ready = 3'h7;

    // Reset held three cycles with in_valid asserted.
    rst_n = 1'b0;
    if4.in_valid = 1'b1;
    if3.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", 32'(if4.in_ready), 0);
      check("rst_out_valid", 32'(if4.out_valid), 0);
      check("rst_busy", 32'(if4.busy), 0);
      check("rst_err_sel", 32'(if4.err_sel), 0);
      check("rst_d3_in_ready", 32'(if3.in_ready), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if4.in_valid = 1'b0;
    if3.in_valid = 1'b0;

    // 3-beat packet to channel 2, one-cycle output latency, busy for 2 cycles.
    base = busy4_cyc;
    send(1'b0, 2, 8'hA1, 1'b0, 2, s);
    check("lat_out_valid", 32'(if4.out_valid), 32'h4);
    send(1'b0, 2, 8'hA2, 1'b0, 2, s);
    send(1'b0, 2, 8'hA3, 1'b1, 2, s);
    check("last_beat_stalls", 32'(s), 0);
    wait_cycles(3);
    check("busy_cycles", 32'(busy4_cyc - base), 2);
    check("pkt2_drained", 32'(q4[2].size()), 0);

    // in_sel moves to 0 after the head: the packet must stay on channel 2.
    send(1'b0, 2, 8'hB1, 1'b0, 2, s);
    send(1'b0, 0, 8'hB2, 1'b0, 2, s);
    send(1'b0, 0, 8'hB3, 1'b1, 2, s);
    wait_cycles(3);
    check("sel_hold_drained", 32'(q4[2].size()), 0);

    // Back-pressure on channel 1 for four cycles.
    fork
      begin
        if4.out_ready = 4'b1101;
        repeat (4) @(posedge clk);
        #1;
        if4.out_ready = 4'hF;
      end
      begin
        send(1'b0, 1, 8'hC1, 1'b0, 1, st[0]);
        send(1'b0, 1, 8'hC2, 1'b0, 1, st[1]);
        send(1'b0, 1, 8'hC3, 1'b0, 1, st[2]);
        send(1'b0, 1, 8'hC4, 1'b1, 1, st[3]);
      end
    join
    check("bp_stall_b1", 32'(st[0]), 0);
    check("bp_stall_b2", 32'(st[1]), 3);
    check("bp_stall_b3", 32'(st[2]), 0);
    check("bp_stall_b4", 32'(st[3]), 0);
    wait_cycles(3);
    check("bp_drained", 32'(q4[1].size()), 0);

    // Independent drain: ch0 stalled, ch3 still delivers.
    if4.out_ready = 4'b1110;
    send(1'b0, 0, 8'h55, 1'b1, 0, s);
    send(1'b0, 3, 8'h66, 1'b1, 3, s);
    check("indep_head_stalls", 32'(s), 0);
    wait_cycles(2);
    check("indep_ch3_drained", 32'(q4[3].size()), 0);
    check("indep_ch0_valid", 32'(if4.out_valid[0]), 1);
    check("indep_ch0_data", 32'(if4.out_data[7:0]), 32'h55);
    check("indep_ch0_pending", 32'(q4[0].size()), 1);
    if4.out_ready = 4'hF;
    wait_cycles(2);
    check("indep_ch0_drained", 32'(q4[0].size()), 0);

    // 3-channel instance: invalid select drops a 2-beat packet.
    base = err3_cyc;
    send(1'b1, 3, 8'hE1, 1'b0, -1, st[0]);
    check("drop_busy", 32'(if3.busy), 1);
    send(1'b1, 0, 8'hE2, 1'b1, -1, st[1]);
    check("drop_stall_b1", 32'(st[0]), 0);
    check("drop_stall_b2", 32'(st[1]), 0);
    wait_cycles(2);
    check("drop_err_pulses", 32'(err3_cyc - base), 1);
    check("drop_no_valid", 32'(if3.out_valid), 0);
    check("drop_busy_end", 32'(if3.busy), 0);
    send(1'b1, 1, 8'h3C, 1'b1, 1, s);
    wait_cycles(2);
    check("after_drop_drained", 32'(q3[1].size()), 0);
    check("after_drop_err", 32'(err3_cyc - base), 1);

    // Reset in the middle of a routed packet.
    if4.out_ready = 4'b1101;
    send(1'b0, 1, 8'h11, 1'b0, -1, s);
    check("midrst_busy_before", 32'(if4.busy), 1);
    rst_n = 1'b0;
    wait_cycles(1);
    check("midrst_out_valid", 32'(if4.out_valid), 0);
    check("midrst_busy", 32'(if4.busy), 0);
    check("midrst_in_ready", 32'(if4.in_ready), 0);
    rst_n = 1'b1;
    if4.out_ready = 4'hF;
    send(1'b0, 3, 8'h77, 1'b1, 3, s);
    check("midrst_new_head_stalls", 32'(s), 0);
    check("midrst_busy_after", 32'(if4.busy), 0);
    wait_cycles(2);
    check("midrst_ch3_drained", 32'(q4[3].size()), 0);

    check("d4_no_err_sel", 32'(err4_cyc), 0);
    for (int c = 0; c < 4; c++) check($sformatf("final_d4_q%0d", c), 32'(q4[c].size()), 0);
    for (int c = 0; c < 3; c++) check($sformatf("final_d3_q%0d", c), 32'(q3[c].size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
